// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the UART-to-ALU packet path.
//   alu_op_e        : opcodes understood by the ALU opcode units
//   HdrLen          : header size in bytes (opcode, reserved, length lo/hi)
//   MinPktLen       : smallest legal packet (header plus one 32-bit operand)
//   parser_state_e  : state encoding of alu_pkt_parser
//   is_known_op()   : true when an opcode byte maps to an ALU unit
// -----------------------------------------------------------------------------
package alu_pkg;

   typedef enum logic [7:0] {
      OpEcho = 8'hEC,
      OpAdd  = 8'hAD,
      OpMul  = 8'h88,
      OpDiv  = 8'h89
   } alu_op_e;

   localparam logic [15:0] HdrLen    = 16'd4;
   localparam logic [15:0] MinPktLen = 16'd8;

   typedef enum logic [2:0] {
      StOpcode   = 3'd0,
      StRsvd     = 3'd1,
      StLenLo    = 3'd2,
      StLenHi    = 3'd3,
      StFirst    = 3'd4,
      StPayload  = 3'd5,
      StDrain    = 3'd6,
      StWaitDone = 3'd7
   } parser_state_e;

   function automatic logic is_known_op(input logic [7:0] op);
      logic known;
      case (op)
         OpEcho, OpAdd, OpMul, OpDiv: known = 1'b1;
         default:                     known = 1'b0;
      endcase
      return known;
   endfunction

endpackage : alu_pkg

// File: rtl/alu_pkt_parser.sv
// -----------------------------------------------------------------------------
// alu_pkt_parser
// Splits the UART byte stream into packets and forwards each payload to the
// ALU opcode units. Packet layout: opcode, reserved, length lo, length hi,
// payload. The length field counts every byte including the 4-byte header.
//
// Handshake: a byte moves on an interface in a cycle where its valid and its
// ready are both high at the rising clock edge. Valid never depends on ready
// from this block; ready may depend on valid only through pass-through.
//
// Ports
//   clk_i       : clock
//   rst_i       : asynchronous active-high reset
//   rx_valid_i  : UART byte valid
//   rx_data_i   : UART byte
//   rx_ready_o  : parser takes the UART byte this cycle
//   opcode_o    : opcode of the current packet, held until the next header
//   start_o     : one-cycle pulse alongside the first payload byte
//   len_o       : number of 32-bit operands in the payload
//   data_o      : payload byte to the ALU
//   valid_o     : payload byte valid to the ALU
//   ready_i     : ALU takes the payload byte
//   done_i      : ALU finished the current packet
//   err_o       : one-cycle pulse when a header is rejected
// -----------------------------------------------------------------------------
module alu_pkt_parser
   import alu_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        rx_valid_i,
   input  logic [7:0]  rx_data_i,
   output logic        rx_ready_o,
   output logic [7:0]  opcode_o,
   output logic        start_o,
   output logic [15:0] len_o,
   output logic [7:0]  data_o,
   output logic        valid_o,
   input  logic        ready_i,
   input  logic        done_i,
   output logic        err_o
);

   parser_state_e state_q;
   logic [7:0]    len_lo_q;
   logic [15:0]   cnt_q;
   logic          err_q;

   logic          rx_fire;
   logic [15:0]   pkt_len;
   logic [15:0]   body_len;
   logic          len_ok;
   logic          last_byte;

   // Full length is only assembled while the MSB byte sits on rx_data_i.
   assign pkt_len  = {rx_data_i, len_lo_q};
   assign body_len = pkt_len - HdrLen;
   assign len_ok   = (pkt_len >= MinPktLen) && (pkt_len[1:0] == 2'b00);

   // body_len >= 4 on every accepted header, so the counter reaches 0 on a
   // transfer and is never decremented from 0.
   assign last_byte = (cnt_q == 16'd1);

   assign rx_fire  = rx_valid_i && rx_ready_o;
   assign err_o    = err_q;

   // Payload path is a zero-latency pass-through; every other state shows
   // an idle ALU interface.
   always_comb begin
      rx_ready_o = 1'b1;
      valid_o    = 1'b0;
      data_o     = 8'h00;
      start_o    = 1'b0;
      case (state_q)
         StFirst: begin
            rx_ready_o = ready_i;
            valid_o    = rx_valid_i;
            data_o     = rx_data_i;
            start_o    = rx_valid_i;
         end
         StPayload: begin
            rx_ready_o = ready_i;
            valid_o    = rx_valid_i;
            data_o     = rx_data_i;
         end
         StWaitDone: begin
            rx_ready_o = 1'b0;
         end
         default: begin
            rx_ready_o = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= StOpcode;
         opcode_o <= 8'h00;
         len_lo_q <= 8'h00;
         len_o    <= 16'h0000;
         cnt_q    <= 16'h0000;
         err_q    <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            StOpcode: begin
               if (rx_fire) begin
                  opcode_o <= rx_data_i;
                  state_q  <= StRsvd;
               end
            end
            StRsvd: begin
               if (rx_fire) state_q <= StLenLo;
            end
            StLenLo: begin
               if (rx_fire) begin
                  len_lo_q <= rx_data_i;
                  state_q  <= StLenHi;
               end
            end
            StLenHi: begin
               if (rx_fire) begin
                  if (!len_ok) begin
                     // Bad length: nothing trustworthy to drain, resync on
                     // the next byte as an opcode.
                     err_q   <= 1'b1;
                     state_q <= StOpcode;
                  end else if (is_known_op(opcode_o)) begin
                     len_o   <= body_len >> 2;
                     cnt_q   <= body_len;
                     state_q <= StFirst;
                  end else begin
                     // Unknown opcode with a sane length: swallow the payload
                     // so the stream stays aligned.
                     err_q   <= 1'b1;
                     cnt_q   <= body_len;
                     state_q <= StDrain;
                  end
               end
            end
            StFirst, StPayload: begin
               if (rx_fire) begin
                  cnt_q   <= cnt_q - 16'd1;
                  state_q <= last_byte ? StWaitDone : StPayload;
               end
            end
            StDrain: begin
               if (rx_fire) begin
                  cnt_q <= cnt_q - 16'd1;
                  if (last_byte) state_q <= StOpcode;
               end
            end
            StWaitDone: begin
               if (done_i) state_q <= StOpcode;
            end
            default: begin
               state_q <= StOpcode;
            end
         endcase
      end
   end

endmodule : alu_pkt_parser

// File: tb/tb_alu_pkt_parser.sv
// -----------------------------------------------------------------------------
// tb_alu_pkt_parser
// Directed packets into alu_pkt_parser. Drivers push the expected payload
// stream ({start, data}) and expected error pulses; a monitor on the falling
// edge pops and compares whenever a payload byte is transferred to the ALU.
// -----------------------------------------------------------------------------
module tb_alu_pkt_parser;
   import alu_pkg::*;

   logic        clk_i;
   logic        rst_i;
   logic        rx_valid_i;
   logic [7:0]  rx_data_i;
   logic        rx_ready_o;
   logic [7:0]  opcode_o;
   logic        start_o;
   logic [15:0] len_o;
   logic [7:0]  data_o;
   logic        valid_o;
   logic        ready_i;
   logic        done_i;
   logic        err_o;

   int checks = 0;
   int errors = 0;
   logic [8:0] exp_q[$];
   int err_pending = 0;

   alu_pkt_parser dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .rx_valid_i (rx_valid_i),
      .rx_data_i  (rx_data_i),
      .rx_ready_o (rx_ready_o),
      .opcode_o   (opcode_o),
      .start_o    (start_o),
      .len_o      (len_o),
      .data_o     (data_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .done_i     (done_i),
      .err_o      (err_o)
   );

   // ---------------- clock / reset ----------------
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every ALU-side transfer must match the next expected byte; any
   // err_o pulse must have been announced by a driver.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_payload: got 0x%0h required no transfer", {start_o, data_o});
            end else begin
               check("payload", {23'd0, start_o, data_o}, {23'd0, exp_q.pop_front()});
            end
         end
         if (!valid_o) check("start_without_valid", {31'd0, start_o}, 32'd0);
         if (err_o) begin
            if (err_pending == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_err: got err_o=1 required 0");
            end else begin
               err_pending--;
               check("err_pulse", {31'd0, err_o}, 32'd1);
            end
         end
      end
   end

   // ---------------- drivers ----------------
   // Offers one byte and returns #1 after the edge that consumed it.
   task automatic send_byte(input logic [7:0] b);
      int waited;
      rx_valid_i = 1'b1;
      rx_data_i  = b;
      waited     = 0;
      forever begin
         @(negedge clk_i);
         if (rx_ready_o) break;
         waited++;
         if (waited > 50) begin
            check("rx_ready_timeout", 32'd0, 32'd1);
            break;
         end
      end
      @(posedge clk_i);
      #1;
      rx_valid_i = 1'b0;
   endtask

   task automatic send_header(input logic [7:0] op, input logic [15:0] len, input logic bad);
      send_byte(op);
      send_byte(8'h00);
      send_byte(len[7:0]);
      if (bad) err_pending++;
      send_byte(len[15:8]);
   endtask

   // Payload whose bytes are expected at the ALU, first one flagged as start.
   task automatic send_payload_byte(input logic [7:0] b, input logic first);
      exp_q.push_back({first, b});
      send_byte(b);
   endtask

   // Parser must hold off the UART in StWaitDone and resume one cycle after done_i.
   task automatic wait_done(input string tag);
      rx_valid_i = 1'b1;
      rx_data_i  = 8'h77;
      @(negedge clk_i);
      check({tag, "_waitdone_ready"}, {31'd0, rx_ready_o}, 32'd0);
      check({tag, "_waitdone_valid"}, {31'd0, valid_o}, 32'd0);
      @(posedge clk_i);
      #1;
      done_i = 1'b1;
      @(negedge clk_i);
      check({tag, "_done_cycle_ready"}, {31'd0, rx_ready_o}, 32'd0);
      @(posedge clk_i);
      #1;
      done_i     = 1'b0;
      rx_valid_i = 1'b0;
      @(negedge clk_i);
      check({tag, "_back_to_opcode"}, {31'd0, rx_ready_o}, 32'd1);
      @(posedge clk_i);
      #1;
   endtask

   // ---------------- stimulus ----------------
   logic [7:0] mul_ops [8];

   initial begin
      mul_ops = '{8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05};
      rst_i      = 1'b1;
      rx_valid_i = 1'b0;
      rx_data_i  = 8'h00;
      ready_i    = 1'b1;
      done_i     = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_ready_during", {31'd0, rx_ready_o}, 32'd1);
      check("rst_opcode", {24'd0, opcode_o}, 32'd0);
      check("rst_len", {16'd0, len_o}, 32'd0);
      rst_i = 1'b0;
      @(negedge clk_i);
      check("rst_ready_after", {31'd0, rx_ready_o}, 32'd1);
      check("rst_valid", {31'd0, valid_o}, 32'd0);
      @(posedge clk_i);
      #1;

      // OpMul, length 12, operands 3 and 5
      send_header(8'h88, 16'd12, 1'b0);
      check("mul_len", {16'd0, len_o}, 32'd2);
      check("mul_opcode", {24'd0, opcode_o}, 32'h88);
      for (int i = 0; i < 8; i++) send_payload_byte(mul_ops[i], i == 0);
      wait_done("mul");

      // Unknown opcode 0x55, length 8: drained, nothing reaches the ALU
      send_header(8'h55, 16'd8, 1'b1);
      for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
      send_header(8'hEC, 16'd8, 1'b0);
      check("echo_after_drain_len", {16'd0, len_o}, 32'd1);
      for (int i = 0; i < 4; i++) send_payload_byte(8'h10 + 8'(i), i == 0);
      wait_done("echo1");

      // OpAdd, length 10: rejected, next byte is an opcode
      send_header(8'hAD, 16'd10, 1'b1);
      send_header(8'h89, 16'd8, 1'b0);
      check("div_after_badlen_opcode", {24'd0, opcode_o}, 32'h89);
      for (int i = 0; i < 4; i++) send_payload_byte(8'h20 + 8'(i), i == 0);
      wait_done("div1");

      // ALU stalls for 3 cycles mid-payload
      send_header(8'hAD, 16'd12, 1'b0);
      for (int i = 0; i < 3; i++) send_payload_byte(8'h30 + 8'(i), i == 0);
      ready_i    = 1'b0;
      rx_valid_i = 1'b1;
      rx_data_i  = 8'h33;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check("stall_rx_ready", {31'd0, rx_ready_o}, 32'd0);
      end
      @(posedge clk_i);
      #1;
      ready_i = 1'b1;
      for (int i = 3; i < 8; i++) send_payload_byte(8'h30 + 8'(i), 1'b0);
      wait_done("stall");

      // done_i during payload is ignored
      send_header(8'hEC, 16'd8, 1'b0);
      send_payload_byte(8'h40, 1'b1);
      send_payload_byte(8'h41, 1'b0);
      done_i = 1'b1;
      @(posedge clk_i);
      #1;
      done_i = 1'b0;
      send_payload_byte(8'h42, 1'b0);
      send_payload_byte(8'h43, 1'b0);
      wait_done("early_done");

      // Reset after 2 payload bytes of a length-12 packet
      send_header(8'h88, 16'd12, 1'b0);
      send_payload_byte(8'h50, 1'b1);
      send_payload_byte(8'h51, 1'b0);
      rst_i      = 1'b1;
      rx_valid_i = 1'b1;
      rx_data_i  = 8'hAA;
      #1;
      check("midrst_opcode", {24'd0, opcode_o}, 32'd0);
      check("midrst_len", {16'd0, len_o}, 32'd0);
      check("midrst_valid", {31'd0, valid_o}, 32'd0);
      check("midrst_start", {31'd0, start_o}, 32'd0);
      check("midrst_data", {24'd0, data_o}, 32'd0);
      check("midrst_err", {31'd0, err_o}, 32'd0);
      check("midrst_ready", {31'd0, rx_ready_o}, 32'd1);
      @(posedge clk_i);
      #1;
      rst_i      = 1'b0;
      rx_valid_i = 1'b0;
      send_header(8'h89, 16'd8, 1'b0);
      check("post_rst_opcode", {24'd0, opcode_o}, 32'h89);
      for (int i = 0; i < 4; i++) send_payload_byte(8'h60 + 8'(i), i == 0);
      wait_done("post_rst");

      // Largest legal length
      send_header(8'hEC, 16'hFFFC, 1'b0);
      check("max_len", {16'd0, len_o}, 32'h3FFE);
      send_payload_byte(8'h70, 1'b1);
      send_payload_byte(8'h71, 1'b0);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;

      repeat (4) @(posedge clk_i);
      check("exp_q_empty", exp_q.size(), 32'd0);
      check("err_all_seen", err_pending, 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_alu_pkt_parser

// File: doc/alu_pkt_parser.md
ALU_PKT_PARSER -- requirements
Module: alu_pkt_parser

Interface
REQ-001 SHALL have no parameters; all constants come from alu_pkg.
REQ-002 SHALL use one clock and an asynchronous, active-high reset. Ports are listed below.
- clk_i  input  1  clock
- rst_i  input  1  asynchronous active-high reset
- rx_valid_i  input  1  received UART byte valid
- rx_data_i  input  8  received UART byte
- rx_ready_o  output  1  parser accepts rx byte this cycle
- opcode_o  output  8  opcode of current packet, held until next header
- start_o  output  1  one-cycle pulse with first payload byte to the ALU
- len_o  output  16  operand count for the ALU (32-bit operands)
- data_o  output  8  payload byte to the ALU
- valid_o  output  1  payload byte valid to the ALU
- ready_i  input  1  ALU accepts payload byte
- done_i  input  1  ALU finished current packet
- err_o  output  1  one-cycle pulse on malformed packet

Function
REQ-003 SHALL define a packet as: byte0 opcode, byte1 reserved, byte2 length LSB, byte3 length MSB, then payload; length counts all bytes, header included.
REQ-004 SHALL treat a header byte as consumed when rx_valid_i && rx_ready_o; rx_ready_o=1 in header states.
REQ-005 SHALL use states StOpcode, StRsvd, StLenLo, StLenHi, StFirst, StPayload, StDrain, StWaitDone; reset state is StOpcode.
REQ-006 SHALL follow the header order StOpcode->StRsvd->StLenLo->StLenHi, advancing one state per consumed byte; it SHALL latch opcode_o in StOpcode.
REQ-007 SHALL validate the header on the StLenHi byte: a valid packet has length>=8 and length[1:0]==0.
REQ-008 SHALL, for a valid header with a known opcode, load len_o=(length-4)>>2 and a byte counter=length-4, then go to StFirst.
REQ-009 SHALL, for a valid header with an unknown opcode (not in alu_pkg), pulse err_o, load the byte counter=length-4 and go to StDrain.
REQ-010 SHALL, for an invalid length, pulse err_o and return to StOpcode without draining.
REQ-011 SHALL, in StFirst and StPayload, pass through with zero latency: valid_o=rx_valid_i, data_o=rx_data_i, rx_ready_o=ready_i.
REQ-012 SHALL, in StFirst, assert start_o=rx_valid_i so that start_o coincides with the first payload byte; it SHALL go to StPayload on the transfer.
REQ-013 SHALL decrement the byte counter on every payload transfer; the transfer that brings the counter to 0 SHALL go to StWaitDone.
REQ-014 SHALL, in StDrain, hold rx_ready_o=1 and valid_o=0, decrement the counter per consumed byte, and return to StOpcode at 0.
REQ-015 SHALL, in StWaitDone, hold rx_ready_o=0 and valid_o=0; done_i=1 SHALL go to StOpcode in the next cycle.
REQ-016 SHALL ignore done_i in every state except StWaitDone.
REQ-017 SHALL hold valid_o=0, start_o=0 and data_o=0 in every state other than StFirst and StPayload.
REQ-018 SHALL accept length=0xFFFC as valid (len_o=0x3FFE); the 16-bit counter SHALL never wrap.

Reset
REQ-019 SHALL, on rst_i assertion at any time including mid-packet, asynchronously force: state=StOpcode, opcode_o=0, len_o=0, counter=0, start_o=0, valid_o=0, err_o=0, data_o=0.
REQ-020 SHALL drive rx_ready_o=1 during and after reset release.
REQ-021 SHALL discard any partial packet on reset; the first byte after reset release is taken as an opcode.

Structure
REQ-022 SHALL take from alu_pkg: the opcode enum (OpEcho=0xEC, OpAdd=0xAD, OpMul=0x88, OpDiv=0x89), the header length constant (4) and the parser state enum.
REQ-023 SHALL need no sub-module; the counter and FSM are inline, and the module sits between uart_rx and the ALU opcode units.

Verification
REQ-024 SHALL cover OpMul with length=12 and operands 0x00000003, 0x00000005: expect len_o=2, start_o with byte 0x00, 8 valid_o bytes, StWaitDone, then StOpcode one cycle after the done_i pulse.
REQ-025 SHALL cover opcode 0x55 with length=8 and 4 payload bytes: expect an err_o pulse, all 4 bytes drained with valid_o=0, and the next packet parsed normally.
REQ-026 SHALL cover OpAdd with length=10: expect an err_o pulse on the length MSB byte, no start_o, and the next byte treated as an opcode.
REQ-027 SHALL cover ready_i held low 3 cycles mid-payload: expect rx_ready_o low for those 3 cycles, no byte lost, and the counter unchanged.
REQ-028 SHALL cover rst_i asserted after 2 payload bytes of a length=12 packet: expect all outputs at reset values immediately and a fresh packet accepted afterward.
REQ-029 SHALL cover a done_i pulse during StPayload: expect it ignored, with StWaitDone still entered after the last byte.
